layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The module SHALL have parameter SHIFT_DIV, default 1, meaning half-period of ser_clk in clk cycles (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, with asynchronous assertion and active-low polarity.
REQ-004 The module SHALL have port enable, input, 1; high requests continuous layer scanning.
REQ-005 The module SHALL have port layer_req, output, 1; high requests the 64-bit column pattern for layer_idx from frame memory.
REQ-006 The module SHALL have port layer_idx, output, 3; the layer currently being processed.
REQ-007 The module SHALL have port layer_data, input, 64; the column pattern, sampled when layer_valid is high.
REQ-008 The module SHALL have port layer_valid, input, 1; the data-present qualifier for layer_data.
REQ-009 The module SHALL have port ser_data, output, 1; the serial column bit sent to the column shift registers.
REQ-010 The module SHALL have port ser_clk, output, 1; the shift clock for the column shift registers.
REQ-011 The module SHALL have port ser_latch, output, 1; a one-cycle pulse that transfers shifted bits to the column drivers.
REQ-012 The module SHALL have port act_start, output, 1; a one-cycle pulse to the layer activator.
REQ-013 The module SHALL have port act_layer, output, 3; the layer index given to the layer activator.
REQ-014 The module SHALL have port act_done, input, 1; the layer activator's one-cycle completion pulse.
REQ-015 The module SHALL have port frame_done, output, 1; a one-cycle pulse after layer 7 completes.
REQ-016 The module SHALL have port busy, output, 1; high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, FETCH, SHIFT, LATCH, START, WAIT_DONE.
REQ-018 In IDLE, the layer counter SHALL be held at 0; when enable=1, the FSM SHALL move to FETCH on the next clock edge.
REQ-019 In FETCH, layer_req SHALL be 1; on a cycle with layer_valid=1, the module SHALL capture layer_data into a 64-bit shift register and go to SHIFT. layer_valid outside FETCH SHALL be ignored. There SHALL be no timeout.
REQ-020 SHIFT SHALL send 64 bits, MSB (bit 63) first, each bit taking 2*SHIFT_DIV cycles:
- ser_data changes only at the start of a bit;
- ser_clk is low for the first SHIFT_DIV cycles and high for the last SHIFT_DIV cycles;
- SHIFT therefore lasts exactly 128*SHIFT_DIV cycles.
REQ-021 A 6-bit bit counter and an 8-bit divider counter SHALL control SHIFT. Leaving SHIFT after bit 0's high phase goes to LATCH, with ser_clk returning low.
REQ-022 LATCH SHALL last one cycle with ser_latch=1, then go to START.
REQ-023 START SHALL last one cycle with act_start=1 and act_layer=layer_idx, then go to WAIT_DONE.
REQ-024 act_layer SHALL equal layer_idx at all times.
REQ-025 In WAIT_DONE, the FSM SHALL wait for act_done=1. act_done in any other state SHALL be ignored.
REQ-026 On act_done, the layer counter SHALL increment modulo 8, with 7 wrapping to 0. When the completed layer is 7, frame_done SHALL pulse in the following cycle.
REQ-027 After act_done, the next state SHALL be FETCH if enable=1, else IDLE.
REQ-028 Deasserting enable mid-layer SHALL NOT abort the layer; the current layer completes through WAIT_DONE before the FSM enters IDLE.
REQ-029 When act_done coincides with enable falling, the layer SHALL count as complete: frame_done fires if the layer was 7, and the FSM enters IDLE.
REQ-030 ser_clk, ser_latch, act_start and layer_req SHALL be registered outputs.
REQ-031 frame_done SHALL be registered.

Reset
REQ-032 While rst_n=0, the following SHALL hold asynchronously:
- state=IDLE; layer_idx=0; shift register=0;
- all counters=0;
- ser_data=0, ser_clk=0, ser_latch=0, act_start=0, layer_req=0, frame_done=0, busy=0.
REQ-033 Reset asserted mid-SHIFT or mid-WAIT_DONE SHALL abandon the operation without emitting ser_latch, act_start or frame_done.
REQ-034 After rst_n rises, the module SHALL resume from IDLE at layer 0.

Verification
REQ-035 Basic layer, SHIFT_DIV=1: enable=1, layer_valid driven 2 cycles after layer_req with data 0x8000_0000_0000_0001, act_done returned 5 cycles after act_start.
- ser_data must be 1 on bit 63, then 0 on bits 62..1, then 1 on bit 0.
- There must be 64 ser_clk rising edges and SHIFT must last exactly 128 cycles.
- One ser_latch pulse must occur, then act_start with act_layer=0 one cycle later.
REQ-036 Full frame: run 8 layers with enable=1.
- act_layer must take 0,1,...,7 across the 8 layers.
- frame_done must pulse exactly once, after layer 7's act_done.
- The next layer_req must show layer_idx=0.
REQ-037 Divider, SHIFT_DIV=3: each ser_clk low and high phase must be 3 cycles, and SHIFT must last 384 cycles.
REQ-038 Enable drop: deassert enable during SHIFT of layer 2.
- ser_latch, act_start(layer 2) and act_done handling must still complete.
- The FSM must then enter IDLE with busy=0 and no further layer_req.
- Re-enabling must restart at layer_idx=0.
REQ-039 Spurious inputs: pulse act_done during SHIFT and layer_valid during WAIT_DONE; the state, the layer counter and all outputs must be unaffected.
REQ-040 Async reset mid-SHIFT: assert rst_n=0 between clock edges at bit 30.
- All outputs must go to 0 immediately, with no ser_latch or act_start pulse.
- After release with enable=1, layer_req must rise within 2 cycles with layer_idx=0.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Layer sequencer bus: frame-memory fetch, column shift-out and layer-activator handshake.
interface layer_sequencer_if;
    localparam int unsigned LAYER_W = 3;
    localparam int unsigned DATA_W  = 64;

    logic               enable;
    logic               layer_req;
    logic [LAYER_W-1:0] layer_idx;
    logic [DATA_W-1:0]  layer_data;
    logic               layer_valid;
    logic               ser_data;
    logic               ser_clk;
    logic               ser_latch;
    logic               act_start;
    logic [LAYER_W-1:0] act_layer;
    logic               act_done;
    logic               frame_done;
    logic               busy;

    // Sequencer side
    modport master (
        input  enable,
        input  layer_data,
        input  layer_valid,
        input  act_done,
        output layer_req,
        output layer_idx,
        output ser_data,
        output ser_clk,
        output ser_latch,
        output act_start,
        output act_layer,
        output frame_done,
        output busy
    );

    // Frame memory / column drivers / activator side
    modport slave (
        output enable,
        output layer_data,
        output layer_valid,
        output act_done,
        input  layer_req,
        input  layer_idx,
        input  ser_data,
        input  ser_clk,
        input  ser_latch,
        input  act_start,
        input  act_layer,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: fetches each layer's 64-bit column pattern, shifts it out
// MSB first on ser_data/ser_clk, latches it, then hands the layer to the
// activator and waits for completion before moving to the next layer.
module layer_sequencer #(
    parameter int unsigned SHIFT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_sequencer_if.master bus
);

    localparam int unsigned LAYER_W = 3;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned DIV_W   = 8;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_FIRST  = BIT_W'(DATA_W - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        START,
        WAIT_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [LAYER_W-1:0] layer_q;
    logic [LAYER_W-1:0] layer_d;
    logic [DATA_W-1:0]  shreg_q;
    logic [DATA_W-1:0]  shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [DIV_W-1:0]   div_cnt_d;
    logic               ser_clk_q;
    logic               ser_clk_d;
    logic               ser_latch_q;
    logic               ser_latch_d;
    logic               act_start_q;
    logic               act_start_d;
    logic               layer_req_q;
    logic               layer_req_d;
    logic               frame_done_q;
    logic               frame_done_d;
    logic               busy_q;
    logic               busy_d;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        ser_clk_d    = ser_clk_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                layer_d = '0;
                if (bus.enable) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (bus.layer_valid) begin
                    shreg_d   = bus.layer_data;
                    bit_cnt_d = BIT_FIRST;
                    div_cnt_d = '0;
                    ser_clk_d = 1'b0;
                    state_d   = SHIFT;
                end
            end

            // Each bit: SHIFT_DIV cycles with ser_clk low, then SHIFT_DIV high.
            // The current bit always sits in shreg_q[63].
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!ser_clk_q) begin
                        ser_clk_d = 1'b1;
                    end else begin
                        ser_clk_d = 1'b0;
                        if (bit_cnt_q == '0) begin
                            shreg_d = '0;
                            state_d = LATCH;
                        end else begin
                            bit_cnt_d = bit_cnt_q - BIT_W'(1);
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            LATCH: begin
                state_d = START;
            end

            START: begin
                state_d = WAIT_DONE;
            end

            // Completion always counts, even if enable fell in the same cycle.
            WAIT_DONE: begin
                if (bus.act_done) begin
                    frame_done_d = (layer_q == LAYER_LAST);
                    if (bus.enable) begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = FETCH;
                    end else begin
                        layer_d = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        layer_req_d = (state_d == FETCH);
        ser_latch_d = (state_d == LATCH);
        act_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q      <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            act_start_q  <= 1'b0;
            layer_req_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            layer_q      <= layer_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            ser_clk_q    <= ser_clk_d;
            ser_latch_q  <= ser_latch_d;
            act_start_q  <= act_start_d;
            layer_req_q  <= layer_req_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.layer_req  = layer_req_q;
    assign bus.layer_idx  = layer_q;
    assign bus.act_layer  = layer_q;
    assign bus.ser_data   = shreg_q[DATA_W-1];
    assign bus.ser_clk    = ser_clk_q;
    assign bus.ser_latch  = ser_latch_q;
    assign bus.act_start  = act_start_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (SHIFT_DIV=1 and 3) against a
// timeline model of the layer protocol, plus directed scenario checks.
module tb_layer_sequencer;

    localparam int DIV_A = 1;
    localparam int DIV_B = 3;

    localparam int W_REQ   = 0;
    localparam int W_NOREQ = 1;
    localparam int W_REQ2  = 2;
    localparam int W_REQ3  = 3;
    localparam int W_START = 4;
    localparam int W_FRAME = 5;
    localparam int W_IDLE  = 6;
    localparam int W_LATCH = 7;

    typedef struct packed {
        logic       busy;
        logic       req;
        logic [2:0] idx;
        logic [2:0] alayer;
        logic       sdata;
        logic       sclk;
        logic       latch;
        logic       start;
        logic       frame;
    } obs_t;

    typedef enum int {M_IDLE, M_FETCH, M_SHIFT, M_LATCH, M_START, M_WAIT} mph_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic spur_valid;
    logic spur_done;

    int checks;
    int fails;

    obs_t        obs        [2];
    obs_t        exp_obs    [2];
    obs_t        act_obs    [2];
    logic        resp_valid [2];
    logic        resp_done  [2];
    logic [63:0] data_bus   [2];
    logic        in_valid   [2];
    logic        in_done    [2];

    layer_sequencer_if if_a ();
    layer_sequencer_if if_b ();

    layer_sequencer #(.SHIFT_DIV(DIV_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
    layer_sequencer #(.SHIFT_DIV(DIV_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.master));

    assign in_valid[0] = resp_valid[0] | spur_valid;
    assign in_done[0]  = resp_done[0] | spur_done;
    assign in_valid[1] = resp_valid[1];
    assign in_done[1]  = resp_done[1];

    assign if_a.enable      = enable;
    assign if_a.layer_data  = data_bus[0];
    assign if_a.layer_valid = in_valid[0];
    assign if_a.act_done    = in_done[0];
    assign if_b.enable      = enable;
    assign if_b.layer_data  = data_bus[1];
    assign if_b.layer_valid = in_valid[1];
    assign if_b.act_done    = in_done[1];

    assign obs[0] = {if_a.busy, if_a.layer_req, if_a.layer_idx, if_a.act_layer, if_a.ser_data,
                     if_a.ser_clk, if_a.ser_latch, if_a.act_start, if_a.frame_done};
    assign obs[1] = {if_b.busy, if_b.layer_req, if_b.layer_idx, if_b.act_layer, if_b.ser_data,
                     if_b.ser_clk, if_b.ser_latch, if_b.act_start, if_b.frame_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pattern(input logic [2:0] l);
        case (l)
            3'd0:    return 64'h8000_0000_0000_0001;
            3'd1:    return 64'hA5A5_5A5A_0F0F_F0F0;
            3'd2:    return 64'hFFFF_0000_1234_5678;
            3'd3:    return 64'h0000_0000_0000_0000;
            3'd4:    return 64'hFFFF_FFFF_FFFF_FFFF;
            3'd5:    return 64'hDEAD_BEEF_CAFE_F00D;
            3'd6:    return 64'h5555_5555_AAAA_AAAA;
            default: return 64'h0123_4567_89AB_CDEF;
        endcase
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Frame memory (valid 2 cycles after req) and activator (done 5 cycles after start)
    int req_age  [2];
    int done_age [2];
    always @(negedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                req_age[i]    = 0;
                done_age[i]   = 0;
                resp_valid[i] = 1'b0;
                resp_done[i]  = 1'b0;
                data_bus[i]   = 64'h0;
            end else begin
                if (obs[i].req) req_age[i]++;
                else            req_age[i] = 0;
                resp_valid[i] = (req_age[i] == 2);
                data_bus[i]   = resp_valid[i] ? pattern(obs[i].idx) : 64'h0;
                if (obs[i].start)          done_age[i] = 1;
                else if (done_age[i] != 0) done_age[i]++;
                resp_done[i] = (done_age[i] == 5);
                if (resp_done[i]) done_age[i] = 0;
            end
        end
    end

    // Timeline model: phase plus cycles elapsed since the pattern was captured
    mph_t        m_ph    [2];
    int          m_t     [2];
    int          m_layer [2];
    logic [63:0] m_data  [2];
    logic        m_frame [2];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ph[i]    = M_IDLE;
                m_t[i]     = 0;
                m_layer[i] = 0;
                m_data[i]  = 64'h0;
                m_frame[i] = 1'b0;
            end else begin
                m_frame[i] = 1'b0;
                case (m_ph[i])
                    M_IDLE:  if (enable) m_ph[i] = M_FETCH;
                    M_FETCH: if (in_valid[i]) begin
                        m_data[i] = data_bus[i];
                        m_t[i]    = 0;
                        m_ph[i]   = M_SHIFT;
                    end
                    M_SHIFT: begin
                        m_t[i]++;
                        if (m_t[i] == 128 * div_of(i)) m_ph[i] = M_LATCH;
                    end
                    M_LATCH: m_ph[i] = M_START;
                    M_START: m_ph[i] = M_WAIT;
                    default: if (in_done[i]) begin
                        m_frame[i] = (m_layer[i] == 7);
                        if (enable) begin
                            m_layer[i] = (m_layer[i] + 1) % 8;
                            m_ph[i]    = M_FETCH;
                        end else begin
                            m_layer[i] = 0;
                            m_ph[i]    = M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle compare against the model plus per-layer shift-out bookkeeping
    logic        prev_req  [2];
    logic        prev_clk  [2];
    logic        in_shift  [2];
    int          shift_len [2];
    int          rises     [2];
    logic [63:0] rx_bits   [2];
    int          latch_cnt [2];
    int          start_cnt [2];
    int          frame_cnt [2];
    int          req_rises [2];
    int          starts_a  [$];
    int          d;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev_req[i] = 1'b0;
                prev_clk[i] = 1'b0;
                in_shift[i] = 1'b0;
            end else begin
                d = div_of(i);
                exp_obs[i]        = '0;
                exp_obs[i].busy   = (m_ph[i] != M_IDLE);
                exp_obs[i].req    = (m_ph[i] == M_FETCH);
                exp_obs[i].idx    = 3'(m_layer[i]);
                exp_obs[i].alayer = 3'(m_layer[i]);
                exp_obs[i].sclk   = (m_ph[i] == M_SHIFT) && ((m_t[i] % (2 * d)) >= d);
                exp_obs[i].latch  = (m_ph[i] == M_LATCH);
                exp_obs[i].start  = (m_ph[i] == M_START);
                exp_obs[i].frame  = m_frame[i];
                act_obs[i] = obs[i];
                if (m_ph[i] == M_SHIFT) exp_obs[i].sdata = m_data[i][63 - m_t[i] / (2 * d)];
                else                    act_obs[i].sdata = 1'b0;
                chk($sformatf("dut%0d.outputs", i), 64'(act_obs[i]), 64'(exp_obs[i]));

                if (obs[i].latch) begin
                    latch_cnt[i]++;
                    chk($sformatf("dut%0d.shift_cycles", i), 64'(shift_len[i]), 64'(128 * d));
                    chk($sformatf("dut%0d.ser_clk_rises", i), 64'(rises[i]), 64'd64);
                    chk($sformatf("dut%0d.shifted_bits", i), rx_bits[i], pattern(obs[i].idx));
                    in_shift[i] = 1'b0;
                end else if (prev_req[i] && !obs[i].req) begin
                    in_shift[i]  = 1'b1;
                    shift_len[i] = 1;
                    rises[i]     = 0;
                    rx_bits[i]   = 64'h0;
                end else if (in_shift[i]) begin
                    shift_len[i]++;
                end
                if (in_shift[i] && obs[i].sclk && !prev_clk[i]) begin
                    rises[i]++;
                    rx_bits[i] = {rx_bits[i][62:0], obs[i].sdata};
                end
                if (obs[i].req && !prev_req[i]) req_rises[i]++;
                if (obs[i].start) begin
                    start_cnt[i]++;
                    if (i == 0) starts_a.push_back(int'(obs[i].alayer));
                end
                if (obs[i].frame) frame_cnt[i]++;
                prev_req[i] = obs[i].req;
                prev_clk[i] = obs[i].sclk;
            end
        end
    end

    task automatic wait_for(input int sel, input int max_cyc, input string what);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < max_cyc && !hit; k++) begin
            @(negedge clk);
            #1;
            case (sel)
                W_REQ:   hit = obs[0].req;
                W_NOREQ: hit = !obs[0].req;
                W_REQ2:  hit = obs[0].req && (obs[0].idx == 3'd2);
                W_REQ3:  hit = obs[0].req && (obs[0].idx == 3'd3);
                W_START: hit = obs[0].start;
                W_FRAME: hit = obs[0].frame;
                W_IDLE:  hit = !obs[0].busy;
                default: hit = obs[0].latch;
            endcase
        end
        if (!hit) chk({"timeout ", what}, 64'd0, 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int lb;
    int sb;
    int rb;

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        spur_valid = 1'b0;
        spur_done  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            latch_cnt[i] = 0;
            start_cnt[i] = 0;
            frame_cnt[i] = 0;
            req_rises[i] = 0;
            shift_len[i] = 0;
            rises[i]     = 0;
            rx_bits[i]   = 64'h0;
        end

        repeat (3) @(negedge clk);
        #1;
        chk("reset.outputs_div1", 64'(obs[0]), 64'h0);
        chk("reset.outputs_div3", 64'(obs[1]), 64'h0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // First layer fetch at layer 0
        wait_for(W_REQ, 3, "first layer_req");
        chk("first.layer_idx", 64'(obs[0].idx), 64'd0);

        // Spurious act_done during SHIFT and layer_valid during WAIT_DONE of layer 3
        wait_for(W_REQ3, 1000, "layer 3 fetch");
        wait_for(W_NOREQ, 10, "layer 3 shift");
        repeat (5) @(negedge clk);
        #1 spur_done = 1'b1;
        @(negedge clk);
        #1 spur_done = 1'b0;
        wait_for(W_START, 300, "layer 3 act_start");
        @(negedge clk);
        #1 spur_valid = 1'b1;
        @(negedge clk);
        #1 spur_valid = 1'b0;

        // Full frame: layers 0..7, one frame_done, next fetch back at layer 0
        wait_for(W_FRAME, 1500, "frame_done");
        chk("frame.frame_done_count", 64'(frame_cnt[0]), 64'd1);
        chk("frame.next_req", 64'(obs[0].req), 64'd1);
        chk("frame.next_layer_idx", 64'(obs[0].idx), 64'd0);
        chk("frame.act_start_count", 64'(starts_a.size()), 64'd8);
        for (int k = 0; k < 8 && k < starts_a.size(); k++)
            chk($sformatf("frame.act_layer[%0d]", k), 64'(starts_a[k]), 64'(k));

        // Enable dropped during SHIFT of layer 2: layer still completes, then idle
        wait_for(W_REQ2, 1000, "layer 2 fetch");
        wait_for(W_NOREQ, 10, "layer 2 shift");
        repeat (10) @(negedge clk);
        #1 enable = 1'b0;
        wait_for(W_IDLE, 400, "idle after enable drop");
        chk("drop.last_act_layer", 64'(starts_a[starts_a.size() - 1]), 64'd2);
        chk("drop.busy", 64'(obs[0].busy), 64'd0);
        chk("drop.layer_idx", 64'(obs[0].idx), 64'd0);
        chk("drop.frame_done_count", 64'(frame_cnt[0]), 64'd1);
        rb = req_rises[0];
        repeat (20) @(negedge clk);
        #1;
        chk("drop.no_layer_req", 64'(req_rises[0] - rb), 64'd0);
        chk("drop.still_idle", 64'(obs[0].busy), 64'd0);
        enable = 1'b1;
        wait_for(W_REQ, 3, "re-enable layer_req");
        chk("reenable.layer_idx", 64'(obs[0].idx), 64'd0);

        // Async reset during bit 30 of the shift
        wait_for(W_NOREQ, 10, "shift before reset");
        repeat (66) @(negedge clk);
        #1;
        lb = latch_cnt[0];
        sb = start_cnt[0];
        rst_n = 1'b0;
        #1;
        chk("async_reset.outputs_div1", 64'(obs[0]), 64'h0);
        chk("async_reset.outputs_div3", 64'(obs[1]), 64'h0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_for(W_REQ, 2, "layer_req after reset");
        chk("after_reset.layer_idx", 64'(obs[0].idx), 64'd0);
        chk("after_reset.no_latch", 64'(latch_cnt[0] - lb), 64'd0);
        chk("after_reset.no_start", 64'(start_cnt[0] - sb), 64'd0);
        wait_for(W_LATCH, 300, "latch after reset");
        repeat (20) @(negedge clk);
        #1;
        chk("div3.layers_completed", 64'(latch_cnt[1] > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
